// File: rtl/digit_sched_pkg.sv
// ============================================================================
// Module      : digit_sched_pkg
// Description : Shared constants, digit type and controller states for the
//               six-digit entry/scroll scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package digit_sched_pkg;

    localparam int DIGITS = 6;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 3;

    typedef logic [DATA_W-1:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_FULL   = 2'd2,
        ST_SCROLL = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/digit_scheduler_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running modulo-TICK_DIV counter that emits a one-cycle
//               tick on its last count while enabled; holds when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] c_LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_count;
    logic         w_last;

    assign w_last = (r_count == c_LAST);
    assign tick   = en && w_last;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/digit_scheduler.sv
// ============================================================================
// Module      : digit_scheduler
// Description : Captures six hex digits one per load press, then rotates them
//               on a slow tick while run is high. Optional macro
//               DIGIT_SCHED_DIR_EN adds a dir port selecting right rotation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_scheduler
    import digit_sched_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic              clock,
    input  logic              reset,
`ifdef DIGIT_SCHED_DIR_EN
    input  logic              dir,
`endif
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    input  logic              clear,
    input  logic              run,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [CNT_W-1:0]  cnt,
    output logic              full
);

    if (DIGITS != 6) begin : g_digits_bad
        $error("digit_scheduler supports exactly six digits");
    end

    state_t             r_state;
    state_t             w_next;
    logic               r_load_q;
    digit_t             r_digit [DIGITS];
    logic [CNT_W-1:0]   r_cnt;
    logic               w_load_rise;
    logic               w_capture;
    logic               w_pre_clr;
    logic               w_pre_en;
    logic               w_tick;

    assign w_load_rise = load && !r_load_q;
    assign w_pre_en    = (r_state == ST_SCROLL) && run && !clear;

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_pre_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load_rise) begin
                    w_capture = 1'b1;
                    w_next    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_load_rise) begin
                    w_capture = 1'b1;
                    if (r_cnt == CNT_W'(DIGITS - 1)) begin
                        w_next = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (run) begin
                    w_next    = ST_SCROLL;
                    w_pre_clr = 1'b1;
                end
            end
            ST_SCROLL: begin
                if (!run) begin
                    w_next = ST_FULL;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Clear outranks any capture or scroll step decided above.
        if (clear) begin
            w_next    = ST_IDLE;
            w_capture = 1'b0;
            w_pre_clr = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_load_q <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_load_q <= load;
        end
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clr   (w_pre_clr),
        .en    (w_pre_en),
        .tick  (w_tick)
    );

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_digit[i] <= '0;
            end
            r_cnt <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    r_digit[i] <= data;
                end
            end
            r_cnt <= r_cnt + 1'b1;
        end else if (w_tick) begin
`ifdef DIGIT_SCHED_DIR_EN
            if (dir) begin
                r_digit[0] <= r_digit[DIGITS-1];
                for (int i = 1; i < DIGITS; i++) begin
                    r_digit[i] <= r_digit[i-1];
                end
            end else begin
                for (int i = 0; i < DIGITS - 1; i++) begin
                    r_digit[i] <= r_digit[i+1];
                end
                r_digit[DIGITS-1] <= r_digit[0];
            end
`else
            for (int i = 0; i < DIGITS - 1; i++) begin
                r_digit[i] <= r_digit[i+1];
            end
            r_digit[DIGITS-1] <= r_digit[0];
`endif
        end
    end

    assign out0 = r_digit[0];
    assign out1 = r_digit[1];
    assign out2 = r_digit[2];
    assign out3 = r_digit[3];
    assign out4 = r_digit[4];
    assign out5 = r_digit[5];
    assign cnt  = r_cnt;
    assign full = (r_state == ST_FULL) || (r_state == ST_SCROLL);

    a_cnt_range: assert property (@(posedge clock) disable iff (reset)
                                  (r_cnt <= CNT_W'(DIGITS)));

endmodule

`default_nettype wire
